// File: rtl/deserializador_if.sv
// Serial-in / word-out bus between a bit source and the deserializador.
// Feature macro: DESERIALIZADOR_PARITY_EN adds the parity_err_out flag.
interface deserializador_if;
    logic       data_in;
    logic       write_in;
    logic       ack_in;
    logic [7:0] data_out;
    logic       data_ready;
    logic       status_out;
`ifdef DESERIALIZADOR_PARITY_EN
    logic       parity_err_out;

    modport master (
        output data_in, write_in, ack_in,
        input  data_out, data_ready, status_out, parity_err_out
    );

    modport slave (
        input  data_in, write_in, ack_in,
        output data_out, data_ready, status_out, parity_err_out
    );
`else
    modport master (
        output data_in, write_in, ack_in,
        input  data_out, data_ready, status_out
    );

    modport slave (
        input  data_in, write_in, ack_in,
        output data_out, data_ready, status_out
    );
`endif
endinterface

// File: rtl/deserializador.sv
// deserializador: assembles serial bits (MSB first) into 8-bit words on a
// 100 kHz enable derived from clock1M, holding each word until acknowledged.
// Feature macro: DESERIALIZADOR_PARITY_EN -- each word carries a 9th
// even-parity bit; bad words are dropped and flagged on parity_err_out.
module deserializador (
    input logic             clock1M,
    input logic             reset,
    deserializador_if.slave bus
);

`ifdef DESERIALIZADOR_PARITY_EN
    // All eight data bits are kept; the parity bit is checked, never stored.
    localparam int         ShiftW  = 8;
    localparam logic [3:0] LastBit = 4'd8;
`else
    // The eighth bit goes straight from data_in into the word, so seven suffice.
    localparam int         ShiftW  = 7;
    localparam logic [3:0] LastBit = 4'd7;
`endif

    typedef enum logic {
        RECEIVE,
        READY
    } stateT;

    stateT             state_q, state_d;
    logic [3:0]        divCount_q, divCount_d;
    logic              tick;
    logic [3:0]        bitCnt_q, bitCnt_d;
    logic [ShiftW-1:0] shiftReg_q, shiftReg_d;
    logic [7:0]        dataOut_q, dataOut_d;
    logic              dataReady_q, dataReady_d;
`ifdef DESERIALIZADOR_PARITY_EN
    logic              parityErr_q, parityErr_d;
    logic              parityOk;
`endif

    assign tick = (divCount_q == 4'd9);

    // Divide-by-10 enable counter: wraps after 9, the cycle that raises tick.
    always_comb begin
        divCount_d = tick ? 4'd0 : divCount_q + 4'd1;
    end

    // Next-state logic; nothing moves except on a tick edge.
    always_comb begin
        state_d     = state_q;
        bitCnt_d    = bitCnt_q;
        shiftReg_d  = shiftReg_q;
        dataOut_d   = dataOut_q;
        dataReady_d = dataReady_q;
`ifdef DESERIALIZADOR_PARITY_EN
        parityErr_d = parityErr_q;
        parityOk    = ~(^{shiftReg_q, bus.data_in});
`endif
        if (tick) begin
`ifdef DESERIALIZADOR_PARITY_EN
            parityErr_d = 1'b0;
`endif
            case (state_q)
                RECEIVE: begin
                    if (bus.write_in) begin
                        if (bitCnt_q == LastBit) begin
                            bitCnt_d = 4'd0;
`ifdef DESERIALIZADOR_PARITY_EN
                            if (parityOk) begin
                                dataOut_d   = shiftReg_q;
                                dataReady_d = 1'b1;
                                state_d     = READY;
                            end else begin
                                parityErr_d = 1'b1;
                            end
`else
                            shiftReg_d  = {shiftReg_q[ShiftW-2:0], bus.data_in};
                            dataOut_d   = {shiftReg_q, bus.data_in};
                            dataReady_d = 1'b1;
                            state_d     = READY;
`endif
                        end else begin
                            shiftReg_d = {shiftReg_q[ShiftW-2:0], bus.data_in};
                            bitCnt_d   = bitCnt_q + 4'd1;
                        end
                    end
                end
                READY: begin
                    if (bus.ack_in) begin
                        dataReady_d = 1'b0;
                        state_d     = RECEIVE;
                    end
                end
            endcase
        end
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge clock1M) begin
        if (reset) begin
            divCount_q  <= 4'd0;
            state_q     <= RECEIVE;
            bitCnt_q    <= 4'd0;
            shiftReg_q  <= '0;
            dataOut_q   <= 8'h00;
            dataReady_q <= 1'b0;
`ifdef DESERIALIZADOR_PARITY_EN
            parityErr_q <= 1'b0;
`endif
        end else begin
            divCount_q  <= divCount_d;
            state_q     <= state_d;
            bitCnt_q    <= bitCnt_d;
            shiftReg_q  <= shiftReg_d;
            dataOut_q   <= dataOut_d;
            dataReady_q <= dataReady_d;
`ifdef DESERIALIZADOR_PARITY_EN
            parityErr_q <= parityErr_d;
`endif
        end
    end

    assign bus.data_out   = dataOut_q;
    assign bus.data_ready = dataReady_q;
    assign bus.status_out = (state_q == RECEIVE);
`ifdef DESERIALIZADOR_PARITY_EN
    assign bus.parity_err_out = parityErr_q;
`endif

endmodule

// File: tb/tb_deserializador.sv
// Bench for deserializador: directed scenarios plus randomized traffic,
// compared every cycle against a queue-based word-assembly model.
module tb_deserializador;

`ifdef DESERIALIZADOR_PARITY_EN
    localparam int WordBits = 9;
`else
    localparam int WordBits = 8;
`endif

    logic clock1M = 1'b0;
    logic reset   = 1'b1;
    int   checkCount = 0;
    int   passCount  = 0;

    deserializador_if bus ();

    deserializador dut (
        .clock1M (clock1M),
        .reset   (reset),
        .bus     (bus)
    );

    // 1 MHz clock.
    always #500 clock1M = ~clock1M;

    int         mDiv    = 0;
    logic       mReady  = 1'b0;
    logic [7:0] mWord   = 8'h00;
    logic       mParErr = 1'b0;
    int         bitQ[$];

    // Reference: collect sampled bits in a queue; a full word is judged at once.
    task automatic modelEdge(input logic r, input logic d, input logic w, input logic a);
        if (r) begin
            mDiv = 0; mReady = 1'b0; mWord = 8'h00; mParErr = 1'b0;
            bitQ.delete();
        end else if (mDiv == 9) begin
            mDiv    = 0;
            mParErr = 1'b0;
            if (mReady) begin
                if (a) mReady = 1'b0;
            end else if (w) begin
                bitQ.push_back(d ? 1 : 0);
                if (bitQ.size() == WordBits) begin
                    int ones;
                    int value;
                    ones  = 0;
                    value = 0;
                    for (int i = 0; i < 8; i++) value = value * 2 + bitQ[i];
                    for (int i = 0; i < WordBits; i++) ones += bitQ[i];
                    if (WordBits == 8 || (ones % 2) == 0) begin
                        mWord  = 8'(value);
                        mReady = 1'b1;
                    end else begin
                        mParErr = 1'b1;
                    end
                    bitQ.delete();
                end
            end
        end else begin
            mDiv++;
        end
    endtask

    task automatic checkValue(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
            $error("[TB] check %s did not hold", tag);
        end
    endtask

    task automatic checkOutput();
        checkValue("data_out", bus.data_out, mWord);
        checkValue("data_ready", {7'd0, bus.data_ready}, {7'd0, mReady});
        checkValue("status_out", {7'd0, bus.status_out}, {7'd0, ~mReady});
`ifdef DESERIALIZADOR_PARITY_EN
        checkValue("parity_err_out", {7'd0, bus.parity_err_out}, {7'd0, mParErr});
`endif
    endtask

    // One clock cycle: drive on the falling edge, model and check just after the rise.
    task automatic applyStimulus(input logic r, input logic d, input logic w, input logic a);
        @(negedge clock1M);
        reset       = r;
        bus.data_in = d;
        bus.write_in = w;
        bus.ack_in  = a;
        @(posedge clock1M);
        modelEdge(r, d, w, a);
        #1;
        checkOutput();
    endtask

    // Random noise until the tick edge, then the requested inputs on it.
    task automatic tickWith(input logic d, input logic w, input logic a);
        while (mDiv != 9)
            applyStimulus(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
        applyStimulus(1'b0, d, w, a);
    endtask

    task automatic sendWord(input logic [7:0] word, input int idleTicks);
        for (int i = 7; i >= 0; i--) begin
            tickWith(word[i], 1'b1, 1'b0);
            if (i > 0) repeat (idleTicks) tickWith(1'($urandom), 1'b0, 1'b0);
        end
`ifdef DESERIALIZADOR_PARITY_EN
        tickWith(^word, 1'b1, 1'b0);
`endif
    endtask

    initial begin
        bus.data_in  = 1'b0;
        bus.write_in = 1'b0;
        bus.ack_in   = 1'b0;

        $display("[TB] reset");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 0);
        checkValue("reset_status", {7'd0, bus.status_out}, 8'd1);

        $display("[TB] word A5 on consecutive ticks");
        sendWord(8'hA5, 0);
        checkValue("a5_data", bus.data_out, 8'hA5);
        checkValue("a5_ready", {7'd0, bus.data_ready}, 8'd1);
        checkValue("a5_status", {7'd0, bus.status_out}, 8'd0);

        $display("[TB] writes ignored while READY");
        repeat (20) tickWith(1'($urandom), 1'b1, 1'b0);
        checkValue("hold_data", bus.data_out, 8'hA5);
        checkValue("hold_ready", {7'd0, bus.data_ready}, 8'd1);
        tickWith(1'b0, 1'b0, 1'b1);
        checkValue("ack_ready", {7'd0, bus.data_ready}, 8'd0);
        checkValue("ack_status", {7'd0, bus.status_out}, 8'd1);
        checkValue("ack_data_kept", bus.data_out, 8'hA5);

        $display("[TB] reset mid-word");
        repeat (3) tickWith(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        sendWord(8'h3C, 0);
        checkValue("after_reset_data", bus.data_out, 8'h3C);
        tickWith(1'b0, 1'b0, 1'b1);

        $display("[TB] word F0 with idle ticks");
        sendWord(8'hF0, 2);
        checkValue("gap_data", bus.data_out, 8'hF0);
        checkValue("gap_ready", {7'd0, bus.data_ready}, 8'd1);
        tickWith(1'b0, 1'b0, 1'b1);

        $display("[TB] ack and write on the same tick");
        sendWord(8'h5A, 0);
        tickWith(1'b1, 1'b1, 1'b1);
        checkValue("ackwrite_ready", {7'd0, bus.data_ready}, 8'd0);
        sendWord(8'h81, 0);
        checkValue("ackwrite_data", bus.data_out, 8'h81);
        tickWith(1'b0, 1'b0, 1'b1);

`ifdef DESERIALIZADOR_PARITY_EN
        $display("[TB] parity error and recovery");
        for (int i = 7; i >= 0; i--) tickWith(((8'hA5 >> i) & 8'h01) != 0, 1'b1, 1'b0);
        tickWith(1'b1, 1'b1, 1'b0);
        checkValue("perr_flag", {7'd0, bus.parity_err_out}, 8'd1);
        checkValue("perr_ready", {7'd0, bus.data_ready}, 8'd0);
        tickWith(1'b0, 1'b0, 1'b0);
        checkValue("perr_cleared", {7'd0, bus.parity_err_out}, 8'd0);
        for (int i = 7; i >= 0; i--) tickWith(((8'hA5 >> i) & 8'h01) != 0, 1'b1, 1'b0);
        tickWith(1'b0, 1'b1, 1'b0);
        checkValue("pok_ready", {7'd0, bus.data_ready}, 8'd1);
        checkValue("pok_data", bus.data_out, 8'hA5);
        tickWith(1'b0, 1'b0, 1'b1);
`endif

        $display("[TB] randomized traffic");
        repeat (300) begin
            if ($urandom_range(0, 49) == 0)
                applyStimulus(1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
            else
                tickWith(1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/deserializador.md
DESERIALIZADOR -- requirements
Module: deserializador

Interface
REQ-001 The block SHALL have the port `clock1M`  input  1  system clock, 1 MHz; all state changes occur on its rising edge.
REQ-002 The block SHALL have the port `reset`  input  1  synchronous, active-high reset.
REQ-003 The block SHALL have the port `data_in`  input  1  serial data bit.
REQ-004 The block SHALL have the port `write_in`  input  1  `data_in` is valid when high.
REQ-005 The block SHALL have the port `ack_in`  input  1  downstream has consumed `data_out`, typically the queue's enqueue path.
REQ-006 The block SHALL have the port `data_out`  output  8  assembled word.
REQ-007 The block SHALL have the port `data_ready`  output  1  `data_out` holds a valid word.
REQ-008 The block SHALL have the port `status_out`  output  1  the block can accept a serial bit.
REQ-009 The block SHALL have the port `parity_err_out`  output  1  parity error flag; present only under DESERIALIZADOR_PARITY_EN.

Function
REQ-010 An internal divide-by-10 counter (0..9) SHALL generate `tick` = 1 when count == 9, giving a 100 kHz enable; the first post-reset cycle is count 0.
REQ-011 All FSM, shift and output updates other than reset SHALL occur only on `clock1M` edges with `tick` = 1; inputs are sampled only on those edges.
REQ-012 The FSM SHALL have exactly two states: RECEIVE and READY.
REQ-013 In RECEIVE, `status_out` SHALL be 1; in READY, `status_out` SHALL be 0.
REQ-014 In RECEIVE, on a tick with `write_in` = 1, the block SHALL shift left, load `data_in` into bit 0 (first bit becomes MSB), and increment `bit_cnt` (0..8).
REQ-015 In RECEIVE, a tick with `write_in` = 0 SHALL leave the shift register and `bit_cnt` unchanged; gaps between bits are allowed.
REQ-016 On the tick that samples the 8th bit, the block SHALL on that same edge load `data_out` with the full word, set `data_ready` = 1, clear `bit_cnt`, and enter READY.
REQ-017 In READY, `data_out` and `data_ready` SHALL hold stable; `write_in` SHALL be ignored and the bit is discarded.
REQ-018 In READY, on a tick with `ack_in` = 1, the block SHALL clear `data_ready` and return to RECEIVE; `data_out` retains its last value.
REQ-019 In READY, when `ack_in` and `write_in` are both high on a tick, the block SHALL process only the ack; the bit is discarded.
REQ-020 `ack_in` in RECEIVE SHALL be ignored.
REQ-021 `ack_in` or `write_in` asserted between ticks SHALL have no effect.
REQ-022 The maximum throughput SHALL be one word per 9 ticks: 8 bits plus 1 ack tick.

Reset
REQ-023 When `reset` = 1 on a `clock1M` edge, the block SHALL set: divide counter = 0, `bit_cnt` = 0, shift register = 8'h00, state = RECEIVE, `data_out` = 8'h00, `data_ready` = 0, `status_out` = 1, `parity_err_out` = 0.
REQ-024 Reset SHALL take priority over `tick` and all inputs.
REQ-025 Reset mid-word SHALL discard the partial word.
REQ-026 Reset in READY SHALL discard the pending word without an ack.

Configuration
REQ-027 With `DESERIALIZADOR_PARITY_EN` defined, each word SHALL be 9 sampled bits: 8 data bits then 1 even-parity bit.
REQ-028 With `DESERIALIZADOR_PARITY_EN` defined, on the 9th bit, if the XOR of all 9 bits is 0, the block SHALL behave as REQ-016.
REQ-029 With `DESERIALIZADOR_PARITY_EN` defined, on a parity failure the block SHALL drop the word, stay in RECEIVE, leave `data_out` and `data_ready` unchanged, and set `parity_err_out` = 1 for exactly one tick period, cleared at the next tick.
REQ-030 Without `DESERIALIZADOR_PARITY_EN`, words SHALL be 8 bits, there SHALL be no parity logic, and the port `parity_err_out` SHALL be absent.

Verification
REQ-031 A bench SHALL cover: reset, then bits 1,0,1,0,0,1,0,1 on consecutive ticks with `write_in` = 1 -> `data_ready` = 1 and `data_out` = 8'hA5 on the 8th tick edge, with `status_out` = 0.
REQ-032 A bench SHALL cover: in READY with `ack_in` = 0, 20 ticks of `write_in` = 1 -> `data_out` stays 8'hA5 and `data_ready` stays 1; then `ack_in` on one tick -> `data_ready` = 0 and `status_out` = 1 at that edge.
REQ-033 A bench SHALL cover: 3 bits sent, then `reset` for 1 cycle, then 8'h3C sent -> `data_out` = 8'h3C, not corrupted by the earlier bits.
REQ-034 A bench SHALL cover: word 8'hF0 sent with 2 idle ticks between each bit -> `data_out` = 8'hF0 after the 8th valid bit only.
REQ-035 A bench SHALL cover: in READY, `ack_in` and `write_in` high on the same tick with `data_in` = 1 -> the next word starts at `bit_cnt` = 0; the following 8 bits 8'h81 -> `data_out` = 8'h81.
REQ-036 A bench SHALL cover, under PARITY_EN: 8'hA5 with parity bit 1 -> `parity_err_out` pulses and `data_ready` stays 0; 8'hA5 with parity bit 0 -> `data_ready` = 1.
